fpu_issue_sched: RTL and testbench
==================================

// Module: fpu_issue_sched
// PURPOSE
//  Sequences the multi-cycle FPU and arbitrates the single FP register-file write port.
//  Sits between instr_decoder and FPU: accepts one FP op at a time, times its latency,
//  then writes back; also arbitrates lwc1 loads for the same write port.
//  Drives a stall that freezes instr_fetch and the regfile/memory write enables.
// PARAMETERS
//  LAT_ADD   2   cycles accept->writeback for add/sub (fp_alu_ctrl 000/001)
//  LAT_MUL   4   mul (010)
//  LAT_DIV   12  div (011)
//  LAT_SQRT  16  sqrt (100)
//  LAT_CVT   3   cvt.s.w / cvt.w.s (101/110)
//  LAT_MOV   1   mov (111)
//  Every LAT_* must be in 1..32; the down-counter is 5 bits.
// PORTS
//  clk          in   1  CPU clock, all state on rising edge
//  reset        in   1  synchronous, active-high
//  issue_valid  in   1  decoder presents an FP arithmetic op this cycle
//  issue_op     in   3  fp_alu_ctrl encoding of the op
//  issue_rd     in   5  FP destination register
//  ld_wr_req    in   1  lwc1 wants to write the FP regfile this cycle
//  ld_wr_rd     in   5  lwc1 destination FP register
//  stall        out  1  hold PC and suppress all architectural writes this cycle
//  fpu_start    out  1  FPU latches operands and op this cycle
//  fpu_op       out  3  op to FPU; valid while fpu_start=1
//  busy         out  1  an FP op is in flight (state != IDLE)
//  ld_wr_grant  out  1  load write accepted this cycle
//  fp_we        out  1  FP regfile write enable
//  fp_wa        out  5  FP regfile write address
//  fp_wsel      out  1  write data select: 0 = FPU result, 1 = load data
// BEHAVIOUR
//  Reset: state IDLE, counter 0, pend_rd 0; every output 0 in the cycle after reset.
//  Reset mid-op: the op is dropped, no writeback, next issue accepted normally.
//  FSM IDLE / EXEC / WB; busy = (state != IDLE).
//  IDLE, issue_valid=1:
//   - Accept: fpu_start=1, fpu_op=issue_op (combinational, same cycle), stall=0.
//   - Latch pend_rd=issue_rd and cnt=LAT(op)-1.
//   - Next state: WB if LAT(op)=1, else EXEC.
//  EXEC: cnt decrements each cycle; at cnt=1, next state is WB.
//  WB (exactly 1 cycle): fp_we=1, fp_wa=pend_rd, fp_wsel=0; next state IDLE.
//  Latency: accept in cycle T -> WB and fp_we in cycle T+LAT(op).
//  Issue while busy (EXEC or WB): stall=1, fpu_start=0. Accepted the first cycle back in
//   IDLE; the decoder holds issue_valid/op/rd stable while stall=1.
//  Load arbitration: ld_wr_grant = ld_wr_req & ~(state==WB) & ~(busy & ld_wr_rd==pend_rd).
//   - FPU writeback wins the port.
//   - WAW against the in-flight dest waits until WB has passed.
//  Granted load: fp_we=1, fp_wa=ld_wr_rd, fp_wsel=1, in the same cycle.
//  stall = (issue_valid & busy) | (ld_wr_req & ~ld_wr_grant).
//  Simultaneous issue_valid and ld_wr_req is illegal from the decoder. If it occurs:
//   issue is handled as above and the load is not granted (stall=1).
//  fp_we is never asserted for two sources in one cycle; fp_wa/fp_wsel are 0 when fp_we=0.
//  Stall does not pause EXEC counting; only architectural writes are suppressed.
// TESTING
//  add rd=3 accepted cyc 0 -> fpu_start cyc 0; fp_we=1, wa=3, wsel=0 at cyc 2 only.
//  sqrt accepted cyc 0, new issue from cyc 5 -> stall=1 cyc 5..16; accepted cyc 17.
//  mul rd=3 in flight: lwc1 rd=7 -> granted same cycle; lwc1 rd=3 -> stall until cyc 5.
//  lwc1 req coinciding with add WB -> stalled 1 cycle, granted next cycle (wsel=1).
//  reset during div EXEC -> no fp_we ever, outputs 0; mov issued next -> fp_we 1 cycle later.
//  mov (LAT=1) back-to-back issues -> accept, WB+stall, accept: 1 op per 2 cycles.

Source files
------------

// File: rtl/fpu_issue_sched.sv
// Issue sequencer for the multi-cycle FPU: times each op's latency and arbitrates the
// single FP register-file write port between FPU writeback and lwc1 loads.
module fpu_issue_sched #(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16,
    parameter int LAT_CVT  = 3,
    parameter int LAT_MOV  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [2:0] issue_op,
    input  logic [4:0] issue_rd,
    input  logic       ld_wr_req,
    input  logic [4:0] ld_wr_rd,
    output logic       stall,
    output logic       fpu_start,
    output logic [2:0] fpu_op,
    output logic       busy,
    output logic       ld_wr_grant,
    output logic       fp_we,
    output logic [4:0] fp_wa,
    output logic       fp_wsel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] pend_rd_q, pend_rd_d;
    logic [4:0] issue_cnt;
    logic       accept;
    logic       in_wb;

    // Counter preload is latency minus one so that WB lands exactly LAT cycles after accept.
    function automatic logic [4:0] cnt_init(input logic [2:0] op);
        int lat;
        case (op)
            3'b000, 3'b001: lat = LAT_ADD;
            3'b010:         lat = LAT_MUL;
            3'b011:         lat = LAT_DIV;
            3'b100:         lat = LAT_SQRT;
            3'b101, 3'b110: lat = LAT_CVT;
            default:        lat = LAT_MOV;
        endcase
        return 5'(lat - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            pend_rd_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        issue_cnt = cnt_init(issue_op);
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    pend_rd_d = issue_rd;
                    cnt_d     = issue_cnt;
                    state_d   = (issue_cnt == 5'd0) ? WB : EXEC;
                end
            end
            EXEC: begin
                // Counting continues through stalls; only architectural writes are held.
                if (cnt_q <= 5'd1) begin
                    cnt_d   = 5'd0;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        in_wb     = (state_q == WB);
        accept    = (state_q == IDLE) && issue_valid;
        fpu_start = accept;
        fpu_op    = accept ? issue_op : 3'd0;

        // Loads lose to FPU writeback, wait out a WAW on the in-flight dest, and are
        // refused outright when the decoder illegally presents an issue alongside them.
        ld_wr_grant = ld_wr_req && !in_wb && !(busy && (ld_wr_rd == pend_rd_q)) && !issue_valid;

        stall   = (issue_valid && busy) || (ld_wr_req && !ld_wr_grant);
        fp_we   = in_wb || ld_wr_grant;
        fp_wsel = ld_wr_grant;
        if (in_wb) begin
            fp_wa = pend_rd_q;
        end else if (ld_wr_grant) begin
            fp_wa = ld_wr_rd;
        end else begin
            fp_wa = 5'd0;
        end
    end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: op latency table plus hand-built corner
// sequences; every register-file write is matched against a cycle-keyed scoreboard.
module tb_fpu_issue_sched;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [2:0] issue_op;
    logic [4:0] issue_rd;
    logic       ld_wr_req;
    logic [4:0] ld_wr_rd;
    logic       stall;
    logic       fpu_start;
    logic [2:0] fpu_op;
    logic       busy;
    logic       ld_wr_grant;
    logic       fp_we;
    logic [4:0] fp_wa;
    logic       fp_wsel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    typedef struct {
        logic [2:0] op;
        logic [4:0] rd;
        int         lat;
    } vec_t;

    typedef struct {
        logic [4:0] wa;
        logic       wsel;
        int         cyc;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];

    fpu_issue_sched dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .ld_wr_req   (ld_wr_req),
        .ld_wr_rd    (ld_wr_rd),
        .stall       (stall),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .busy        (busy),
        .ld_wr_grant (ld_wr_grant),
        .fp_we       (fp_we),
        .fp_wa       (fp_wa),
        .fp_wsel     (fp_wsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [2:0] op, input logic [4:0] rd,
                                 input logic lr, input logic [4:0] lrd);
        issue_valid = iv;
        issue_op    = op;
        issue_rd    = rd;
        ld_wr_req   = lr;
        ld_wr_rd    = lrd;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, stall, 0);
        checkOutput({tag, "_fpu_start"}, fpu_start, 0);
        checkOutput({tag, "_fpu_op"}, fpu_op, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_grant"}, ld_wr_grant, 0);
        checkOutput({tag, "_fp_we"}, fp_we, 0);
        checkOutput({tag, "_fp_wa"}, fp_wa, 0);
        checkOutput({tag, "_fp_wsel"}, fp_wsel, 0);
    endtask

    task automatic expectWrite(input logic [4:0] wa, input logic wsel, input int c);
        sb.push_back('{wa: wa, wsel: wsel, cyc: c});
    endtask

    // Every write seen on the port must match a scoreboard entry due in this very cycle.
    task automatic monitorWrites();
        int idx;
        forever begin
            @(negedge clk);
            if (!reset && fp_we) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].cyc == cyc) idx = i;
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wb_unexpected cyc=%0d got write wa=%0d wsel=%0d expected no write",
                             cyc, fp_wa, fp_wsel);
                end else begin
                    checkOutput("wb_wa", fp_wa, sb[idx].wa);
                    checkOutput("wb_wsel", fp_wsel, sb[idx].wsel);
                    sb.delete(idx);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{op: 3'b000, rd: 5'd3,  lat: 2};
        vecs[1] = '{op: 3'b001, rd: 5'd8,  lat: 2};
        vecs[2] = '{op: 3'b010, rd: 5'd12, lat: 4};
        vecs[3] = '{op: 3'b011, rd: 5'd17, lat: 12};
        vecs[4] = '{op: 3'b100, rd: 5'd21, lat: 16};
        vecs[5] = '{op: 3'b101, rd: 5'd25, lat: 3};
        vecs[6] = '{op: 3'b110, rd: 5'd30, lat: 3};
        vecs[7] = '{op: 3'b111, rd: 5'd31, lat: 1};

        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        reset = 1'b1;
        fork
            monitorWrites();
        join_none
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("rst");
        tick();

        for (int v = 0; v < 8; v++) begin
            applyStimulus(1, vecs[v].op, vecs[v].rd, 0, 5'd0);
            t0 = cyc;
            expectWrite(vecs[v].rd, 1'b0, t0 + vecs[v].lat);
            @(negedge clk);
            checkOutput("acc_start", fpu_start, 1);
            checkOutput("acc_op", fpu_op, vecs[v].op);
            checkOutput("acc_stall", stall, 0);
            checkOutput("acc_busy", busy, 0);
            tick();
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
            for (int k = 1; k <= vecs[v].lat; k++) begin
                @(negedge clk);
                checkOutput("run_busy", busy, 1);
                checkOutput("run_we", fp_we, (k == vecs[v].lat) ? 1 : 0);
                tick();
            end
            @(negedge clk);
            checkOutput("ret_idle", busy, 0);
            tick();
        end

        // sqrt in flight, next issue held from cycle 5: stalled through WB, accepted at 17.
        applyStimulus(1, 3'b100, 5'd20, 0, 5'd0);
        t0 = cyc;
        expectWrite(5'd20, 1'b0, t0 + 16);
        @(negedge clk);
        checkOutput("sq_start", fpu_start, 1);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        repeat (4) tick();
        applyStimulus(1, 3'b000, 5'd9, 0, 5'd0);
        for (int c = 5; c <= 17; c++) begin
            @(negedge clk);
            checkOutput("sq_stall", stall, (c < 17) ? 1 : 0);
            checkOutput("sq_start2", fpu_start, (c == 17) ? 1 : 0);
            tick();
        end
        expectWrite(5'd9, 1'b0, t0 + 19);
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        repeat (3) tick();

        // mul rd=3 in flight: independent load granted at once, WAW load waits past WB.
        applyStimulus(1, 3'b010, 5'd3, 0, 5'd0);
        t0 = cyc;
        expectWrite(5'd3, 1'b0, t0 + 4);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 1, 5'd7);
        expectWrite(5'd7, 1'b1, t0 + 1);
        @(negedge clk);
        checkOutput("ld_free_grant", ld_wr_grant, 1);
        checkOutput("ld_free_stall", stall, 0);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 1, 5'd3);
        expectWrite(5'd3, 1'b1, t0 + 5);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checkOutput("ld_waw_grant", ld_wr_grant, (c == 5) ? 1 : 0);
            checkOutput("ld_waw_stall", stall, (c < 5) ? 1 : 0);
            tick();
        end
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);

        // Load colliding with add writeback loses the port for one cycle.
        applyStimulus(1, 3'b000, 5'd5, 0, 5'd0);
        t0 = cyc;
        expectWrite(5'd5, 1'b0, t0 + 2);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 1, 5'd11);
        expectWrite(5'd11, 1'b1, t0 + 3);
        @(negedge clk);
        checkOutput("ldwb_grant0", ld_wr_grant, 0);
        checkOutput("ldwb_stall0", stall, 1);
        tick();
        @(negedge clk);
        checkOutput("ldwb_grant1", ld_wr_grant, 1);
        checkOutput("ldwb_stall1", stall, 0);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);

        // Illegal simultaneous issue and load: issue accepted, load refused.
        applyStimulus(1, 3'b001, 5'd14, 1, 5'd15);
        t0 = cyc;
        expectWrite(5'd14, 1'b0, t0 + 2);
        @(negedge clk);
        checkOutput("both_start", fpu_start, 1);
        checkOutput("both_grant", ld_wr_grant, 0);
        checkOutput("both_stall", stall, 1);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        repeat (2) tick();

        // Back-to-back mov: accept, WB with stall, accept.
        applyStimulus(1, 3'b111, 5'd1, 0, 5'd0);
        t0 = cyc;
        expectWrite(5'd1, 1'b0, t0 + 1);
        @(negedge clk);
        checkOutput("mov_start0", fpu_start, 1);
        checkOutput("mov_stall0", stall, 0);
        tick();
        applyStimulus(1, 3'b111, 5'd4, 0, 5'd0);
        @(negedge clk);
        checkOutput("mov_start1", fpu_start, 0);
        checkOutput("mov_stall1", stall, 1);
        tick();
        expectWrite(5'd4, 1'b0, t0 + 3);
        @(negedge clk);
        checkOutput("mov_start2", fpu_start, 1);
        checkOutput("mov_stall2", stall, 0);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        @(negedge clk);
        checkOutput("mov_busy3", busy, 1);
        checkOutput("mov_stall3", stall, 0);
        tick();

        // Reset during div EXEC drops the op; a following mov behaves normally.
        applyStimulus(1, 3'b011, 5'd6, 0, 5'd0);
        @(negedge clk);
        checkOutput("div_start", fpu_start, 1);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("midrst");
        tick();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checkOutput("postrst_we", fp_we, 0);
            checkOutput("postrst_busy", busy, 0);
            tick();
        end
        applyStimulus(1, 3'b111, 5'd2, 0, 5'd0);
        t0 = cyc;
        expectWrite(5'd2, 1'b0, t0 + 1);
        @(negedge clk);
        checkOutput("postrst_start", fpu_start, 1);
        tick();
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0);
        repeat (3) tick();

        checkOutput("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
